// File: rtl/inv_cipher.sv
// Iterative AES inverse cipher: one round per clock, round keys requested NR down to 0
// from an external key source through keyIdx/roundKey.
module inv_cipher #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] roundKey,
  output logic [3:0]   keyIdx,
  output logic         busy,
  output logic         done,
  output logic [127:0] out
);

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  state_e       state_q;
  logic [3:0]   rnd_q;
  logic [127:0] stm_q;
  logic         busy_q, done_q;
  logic [127:0] r_stm;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^
                         gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^
                         gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^
                         gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^
                         gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign r_stm = inv_sub_bytes(inv_shift_rows(stm_q)) ^ roundKey;

  // Idle and Done both pre-fetch the last round key for the next block.
  always_comb begin
    keyIdx = 4'(NR);
    unique case (state_q)
      StRound: keyIdx = rnd_q;
      StFinal: keyIdx = 4'd0;
      default: keyIdx = 4'(NR);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rnd_q   <= '0;
      stm_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            stm_q   <= in ^ roundKey;
            rnd_q   <= 4'(NR - 1);
            state_q <= StRound;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StRound: begin
          stm_q <= inv_mix_columns(r_stm);
          if (rnd_q == 4'd1) begin
            state_q <= StFinal;
          end else begin
            rnd_q <= rnd_q - 4'd1;
          end
        end
        StFinal: begin
          stm_q   <= r_stm;
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = stm_q;

endmodule

// File: tb/tb_inv_cipher.sv
// Directed FIPS-197 vectors for inv_cipher at NR = 10, 12 and 14, with a key-expansion
// model serving round keys on demand.
module tb_inv_cipher;

  logic         clk;
  logic         reset;
  logic [127:0] in_r;
  logic         start [3];
  logic [3:0]   kidx  [3];
  logic         busy  [3];
  logic         done  [3];
  logic [127:0] outv  [3];
  logic [127:0] rk    [3];
  logic [127:0] keys  [3][16];

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CtC2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CtC3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;

  inv_cipher #(.NR(10)) u_dut10 (
    .clk(clk), .reset(reset), .start(start[0]), .in(in_r), .roundKey(rk[0]),
    .keyIdx(kidx[0]), .busy(busy[0]), .done(done[0]), .out(outv[0])
  );
  inv_cipher #(.NR(12)) u_dut12 (
    .clk(clk), .reset(reset), .start(start[1]), .in(in_r), .roundKey(rk[1]),
    .keyIdx(kidx[1]), .busy(busy[1]), .done(done[1]), .out(outv[1])
  );
  inv_cipher #(.NR(14)) u_dut14 (
    .clk(clk), .reset(reset), .start(start[2]), .in(in_r), .roundKey(rk[2]),
    .keyIdx(kidx[2]), .busy(busy[2]), .done(done[2]), .out(outv[2])
  );

  // Key source: combinational lookup of the expanded schedule.
  assign rk[0] = keys[0][kidx[0]];
  assign rk[1] = keys[1][kidx[1]];
  assign rk[2] = keys[2][kidx[2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [255:0] seq_key(input int nbytes);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < nbytes; i++) k[255-8*i -: 8] = 8'(i);
    return k;
  endfunction

  task automatic load_keys(input int d, input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) keys[d][r] = '0;
    for (int r = 0; r <= nr; r++) keys[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a negedge with the DUT idle or done; returns at the negedge after done rises.
  task automatic run_block(input int d, input int nr, input logic [127:0] ct,
                           input logic [127:0] pt, input string tag, input int inject);
    check($sformatf("%s/kidx_pre", tag), 128'(kidx[d]), 128'(nr));
    in_r     = ct;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    in_r     = ~ct;
    for (int j = 0; j < nr; j++) begin
      check($sformatf("%s/kidx%0d", tag, j), 128'(kidx[d]), 128'(nr - 1 - j));
      check($sformatf("%s/busy%0d", tag, j), 128'(busy[d]), 128'(1));
      check($sformatf("%s/done%0d", tag, j), 128'(done[d]), 128'(0));
      if (j == inject) begin
        start[d] = 1'b1;
        in_r     = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      start[d] = 1'b0;
    end
    check($sformatf("%s/done", tag), 128'(done[d]), 128'(1));
    check($sformatf("%s/busy_end", tag), 128'(busy[d]), 128'(0));
    check($sformatf("%s/kidx_end", tag), 128'(kidx[d]), 128'(nr));
    check($sformatf("%s/out", tag), outv[d], pt);
  endtask

  initial begin
    reset = 1'b1;
    in_r  = '0;
    for (int d = 0; d < 3; d++) start[d] = 1'b0;
    @(negedge clk);
    check("rst/out", outv[0], '0);
    check("rst/busy", 128'(busy[0]), 128'(0));
    check("rst/done", 128'(done[0]), 128'(0));
    check("rst/kidx10", 128'(kidx[0]), 128'(10));
    check("rst/kidx14", 128'(kidx[2]), 128'(14));
    reset = 1'b0;
    @(negedge clk);

    load_keys(0, seq_key(16), 4, 10);
    run_block(0, 10, CtC1, PtC, "c1", -1);

    load_keys(1, seq_key(24), 6, 12);
    run_block(1, 12, CtC2, PtC, "c2", -1);

    load_keys(2, seq_key(32), 8, 14);
    run_block(2, 14, CtC3, PtC, "c3", -1);
    repeat (3) @(negedge clk);
    check("c3/hold_done", 128'(done[2]), 128'(1));
    check("c3/hold_out", outv[2], PtC);

    // Garbage start during the run must not disturb timing or result.
    run_block(0, 10, CtC1, PtC, "ign", 4);
    @(negedge clk);
    check("ign/no_restart", 128'(busy[0]), 128'(0));

    // Asynchronous reset between edges in the middle of a run.
    in_r     = CtC1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mrst/out", outv[0], '0);
    check("mrst/busy", 128'(busy[0]), 128'(0));
    check("mrst/done", 128'(done[0]), 128'(0));
    check("mrst/kidx", 128'(kidx[0]), 128'(10));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_block(0, 10, CtC1, PtC, "fresh", -1);

    // Back-to-back: next block launched in the first Done cycle with a new key.
    load_keys(0, {KeyB, 128'h0}, 4, 10);
    check("b2b/held_out", outv[0], PtC);
    run_block(0, 10, CtB, PtB, "b2b", -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inv_cipher.md
# inv_cipher

- Iterative AES inverse cipher (decryption), one round per clock, for the FIPS-197 key sizes selected by `NR`.
- Sits alongside the encryption datapath and shares the same externally supplied round-key interface, but requests keys in reverse order (`NR` down to 0).
- A request/response handshake loads a 128-bit ciphertext, and the block holds the 128-bit plaintext until the next start.

## Interface

Parameters:
- `NR`, default 10: number of rounds. Legal values are 10, 12 and 14 (AES-128/192/256).

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin decryption of `in`. Sampled only when not busy.
- `in`, input, 128: ciphertext block. Sampled on the accepted `start` edge only.
- `roundKey`, input, 128: round key `w[keyIdx]`. Driven combinationally by the key source in the same cycle `keyIdx` is presented.
- `keyIdx`, output, 4: index of the round key required this cycle.
- `busy`, output, 1: decryption in progress.
- `done`, output, 1: `out` holds a valid plaintext.
- `out`, output, 128: plaintext, driven from the state register.

## Operation

- State matrix byte order matches the encryption datapath: bits [127:120] are byte 0 (row 0, column 0), column-major.
- Combinational helpers on `stm`:
  - `invshiftrows`: row r rotated right by r bytes.
  - `invsubbytes`: inverse S-box applied to each byte.
  - `invmixcolumns`: column multiply by {0e,0b,0d,09}.
- Round datapath: `rStm = invsubbytes(invshiftrows(stm)) ^ roundKey`. `invmixcolumns(rStm)` is applied in middle rounds only.
- FSM states: IDLE, ROUND, FINAL, DONE. The down-counter `rnd` is 4 bits.
- IDLE: `keyIdx = NR`. On `start`: `stm <= in ^ roundKey`, `rnd <= NR-1`, go to ROUND.
- ROUND: `keyIdx = rnd`. `stm <= invmixcolumns(rStm)`.
  - If `rnd == 1`: go to FINAL.
  - Otherwise: `rnd <= rnd-1`.
- FINAL: `keyIdx = 0`. `stm <= rStm` (no invmixcolumns). Go to DONE.
- DONE: `keyIdx = NR` (pre-fetch for the next block). `stm` holds.
  - On `start`: behave exactly as IDLE-with-`start` (back-to-back blocks).
- `busy` = (state is ROUND or FINAL). `done` = (state is DONE).
- `start` while `busy` is ignored; `in` changes during `busy` have no effect.
- Reset, including mid-operation: asynchronously forces IDLE with `stm = 0` and `rnd = 0`.
  - Outputs after reset: `out = 0`, `done = 0`, `busy = 0`, `keyIdx = NR`.
- `keyIdx` takes values in 0..`NR` only. Any unreachable state encoding recovers to IDLE.

## Timing

- Cycle 0 is the edge where `start` is accepted.
- Edges 1..NR-1 perform ROUND for `rnd` = NR-1 down to 1. Edge NR performs FINAL.
- `done` rises after edge NR:
  - 10 cycles for AES-128, 12 for AES-192, 14 for AES-256.
  - `busy` is high for exactly NR-1... no: `busy` is high for NR cycles — one ROUND cycle per edge 1..NR-1 plus the FINAL cycle (ROUND entered after edge 0 through FINAL exited at edge NR).
- Back-to-back: `start` held or pulsed in DONE launches the next block. The next `done` follows NR cycles later, so throughput is one block per NR+1 cycles.
- `done` and `out` stay stable indefinitely in DONE until `start` or `reset`.
- `keyIdx` is a pure function of state and `rnd`, with no input-to-`keyIdx` combinational path.
- `roundKey`→`stm` is the only cross-module combinational path. The key source must settle `roundKey` within the cycle.

## Test plan

- **AES-128 (C.1):**
  - Stimulus: `in` = 69c4e0d86a7b0430d8cdb78070b4c55a. The bench's key model expands key 000102…0f and serves `w[keyIdx]`.
  - Response: after 10 cycles `done = 1` and `out` = 00112233445566778899aabbccddeeff.
  - `keyIdx` sequence from the start cycle: 10, 9, …, 1, 0.
- **AES-128 (Appendix B):**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, `in` = 3925841d02dc09fbdc118597196a0b32.
  - Response: `out` = 3243f6a8885a308d313198a2e0370734.
- **`NR = 14` (C.3):**
  - Stimulus: key 000102…1f, `in` = 8ea2b7ca516745bfeafc49904b496089.
  - Response: after 14 cycles `out` = 00112233445566778899aabbccddeeff.
  - Also run C.2 with `NR = 12`: `in` = dda97ca4864cdfe06eaf70a0ec0d7191, expect the same plaintext.
- **Ignored start:**
  - Stimulus: pulse `start` with garbage `in` at cycle 4 of the C.1 decryption.
  - Response: result still 00112233…eeff at cycle 10, with no extra `done` pulse or timing shift.
- **Reset mid-operation:**
  - Stimulus: assert `reset` asynchronously (between edges) at cycle 5.
  - Response: immediately `out = 0`, `busy = 0`, `done = 0`, `keyIdx = 10`.
  - Then a fresh C.1 run completes correctly in 10 cycles.
- **Back-to-back:**
  - Stimulus: assert `start` in the first DONE cycle with the Appendix B ciphertext.
  - Response: `done` drops for 10 cycles, then rises with 3243f6a8…0734. The previous `out` is held until that start edge.
